// File: rtl/hex_display_arbiter_pkg.sv
// Shared constants, state encoding and sizing helper for the HEX display arbiter.
package hex_display_arbiter_pkg;

  localparam logic [6:0] HEX_BLANK  = 7'h7F;
  localparam int         NUM_REQ    = 3;
  localparam int         NUM_DIGITS = 6;

  // Requester indices, lowest index wins arbitration.
  localparam int REQ_AUTH = 0;
  localparam int REQ_GAME = 1;
  localparam int REQ_IDLE = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Counter width for a count range of n states, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_display_arbiter_if.sv
// Requester-side bundle: level requests, blink enables, digit buses, grant and HEX outputs.
interface hex_display_arbiter_if;

  logic [hex_display_arbiter_pkg::NUM_REQ-1:0]           req;
  logic [hex_display_arbiter_pkg::NUM_REQ-1:0]           blink_en;
  logic [41:0]                                           digits0;
  logic [41:0]                                           digits1;
  logic [41:0]                                           digits2;
  logic [hex_display_arbiter_pkg::NUM_REQ-1:0]           grant;
  // hex[0] drives Hex1, hex[5] drives Hex6.
  logic [hex_display_arbiter_pkg::NUM_DIGITS-1:0][6:0]   hex;

  // Requesters and the board side.
  modport master (
    output req, blink_en, digits0, digits1, digits2,
    input  grant, hex
  );

  // The arbiter.
  modport slave (
    input  req, blink_en, digits0, digits1, digits2,
    output grant, hex
  );

endinterface

// File: rtl/hex_display_arbiter_pick3.sv
// Combinational fixed-priority picker: bit 0 wins, one-hot result plus valid flag.
module fixed_priority_pick3 (
  input  logic [2:0] req_i,
  output logic [2:0] onehot_o,
  output logic       valid_o
);

  // Isolate the lowest-index active request.
  always_comb begin
    // NOTE: default assignment first so no latch is inferred on any path.
    onehot_o = 3'b000;
    if (req_i[0])      onehot_o = 3'b001;
    else if (req_i[1]) onehot_o = 3'b010;
    else if (req_i[2]) onehot_o = 3'b100;
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares six seven-segment digits between three requesters with fixed priority,
// a minimum ownership time, a blank gap on every hand-over and optional blinking.
module hex_display_arbiter
  import hex_display_arbiter_pkg::*;
#(
  parameter int unsigned MIN_HOLD     = 50_000_000,
  parameter int unsigned BLANK_CYCLES = 5_000_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hex_display_arbiter_if.slave  bus
);

  localparam int HOLD_W  = cnt_width(MIN_HOLD);
  localparam int GAP_W   = cnt_width(BLANK_CYCLES);
  localparam int BLINK_W = cnt_width(BLINK_CYCLES);

  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MIN_HOLD - 1);
  localparam logic [GAP_W-1:0]   GAP_MAX   = GAP_W'(BLANK_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);

  localparam logic [NUM_DIGITS-1:0][6:0] ALL_BLANK = {NUM_DIGITS{HEX_BLANK}};

  state_e                       state_q;
  logic [NUM_REQ-1:0]           grant_q;
  logic [NUM_DIGITS-1:0][6:0]   hex_q;
  logic [HOLD_W-1:0]            hold_q;
  logic [GAP_W-1:0]             gap_q;
  logic [BLINK_W-1:0]           blink_q;
  logic                         phase_q;

  logic [NUM_REQ-1:0]           pick_onehot;
  logic                         pick_valid;
  logic [NUM_DIGITS-1:0][6:0]   owner_digits;
  logic [NUM_DIGITS-1:0][6:0]   owner_hex;
  logic                         owner_req;
  logic                         higher_req;
  logic                         hold_done;
  logic                         owner_release;

  // Same picker serves the IDLE arbitration and the final GAP cycle.
  fixed_priority_pick3 u_pick (
    .req_i    (bus.req),
    .onehot_o (pick_onehot),
    .valid_o  (pick_valid)
  );

  // Route the current owner's digit bus; non-owners are ignored.
  always_comb begin
    owner_digits = bus.digits2;
    if (grant_q[REQ_AUTH])      owner_digits = bus.digits0;
    else if (grant_q[REQ_GAME]) owner_digits = bus.digits1;
  end

  // Requests below the owner's index are the only ones allowed to preempt.
  assign owner_req     = |(bus.req & grant_q);
  assign higher_req    = |(bus.req & (grant_q - 3'd1));
  assign hold_done     = (hold_q == HOLD_MAX);
  assign owner_release = !owner_req || (hold_done && higher_req);
  assign owner_hex     = (|(bus.blink_en & grant_q) && phase_q) ? ALL_BLANK : owner_digits;

  // Ownership FSM with registered grant and segment outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      hex_q   <= ALL_BLANK;
      hold_q  <= '0;
      gap_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_OWN;
            grant_q <= pick_onehot;
            hold_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
          end
        end
        ST_OWN: begin
          if (owner_release) begin
            state_q <= ST_GAP;
            grant_q <= '0;
            hex_q   <= ALL_BLANK;
            gap_q   <= '0;
          end else begin
            if (!hold_done) hold_q <= hold_q + 1'b1;
            hex_q <= owner_hex;
            if (blink_q == BLINK_MAX) begin
              blink_q <= '0;
              phase_q <= ~phase_q;
            end else begin
              blink_q <= blink_q + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_MAX) begin
            if (pick_valid) begin
              state_q <= ST_OWN;
              grant_q <= pick_onehot;
              hold_q  <= '0;
              blink_q <= '0;
              phase_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.hex   = hex_q;

endmodule
